// File: rtl/mbc3_rtc_ctrl.sv
// rtl/mbc3_rtc_ctrl.sv - MBC3 real-time clock: live/latched time registers, latch sequence, catch-up stepping
//
// Ports:
//   clk_sys     in   1   system clock
//   reset       in   1   synchronous active-high reset
//   enable      in   1   mapper selected; low holds everything at reset values
//   sec_tick    in   1   one-cycle pulse per real-time second
//   reg_wr      in   1   CPU write to RTC register selected by reg_idx
//   latch_wr    in   1   CPU write to the latch register
//   reg_idx     in   3   0=sec 1=min 2=hour 3=day[7:0] 4=control
//   wr_data     in   8   CPU write data
//   rd_data     out  8   latched value of the selected register
//   load_valid  in   1   apply load_time / load_diff
//   load_time   in   32  {3'b0, halt, ovf, day[9:0], hour[4:0], min[5:0], sec[5:0]}
//   load_diff   in   32  elapsed seconds to catch up
//   saved_time  out  32  packed live time, same layout as load_time
//   busy        out  1   catch-up pending

module mbc3_rtc_ctrl (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        enable,
   input  logic        sec_tick,
   input  logic        reg_wr,
   input  logic        latch_wr,
   input  logic [2:0]  reg_idx,
   input  logic [7:0]  wr_data,
   output logic [7:0]  rd_data,
   input  logic        load_valid,
   input  logic [31:0] load_time,
   input  logic [31:0] load_diff,
   output logic [31:0] saved_time,
   output logic        busy
);

   localparam logic [0:0] CU_IDLE    = 1'b0;
   localparam logic [0:0] CU_CATCHUP = 1'b1;
   localparam logic [0:0] LT_ARMED_N = 1'b0;
   localparam logic [0:0] LT_ARMED   = 1'b1;

   // live time
   logic [5:0]  sec, min;
   logic [4:0]  hour;
   logic [8:0]  day;
   logic        halt, ovf;

   // latched copies seen by the CPU
   logic [5:0]  l_sec, l_min;
   logic [4:0]  l_hour;
   logic [8:0]  l_day;
   logic        l_halt, l_ovf;

   logic [0:0]  cu_state, latch_state;
   logic [31:0] cnt;

   // next-state values
   logic [5:0]  n_sec, n_min, nl_sec, nl_min;
   logic [4:0]  n_hour, nl_hour;
   logic [8:0]  n_day, nl_day;
   logic        n_halt, n_ovf, nl_halt, nl_ovf;
   logic [0:0]  n_cu_state, n_latch_state;
   logic [31:0] n_cnt;
   logic        do_step, do_copy, live_change;

   // one increment step applied to the current live time
   logic [5:0]  inc_sec, inc_min;
   logic [4:0]  inc_hour;
   logic [8:0]  inc_day;
   logic        inc_ovf;
   logic        s_wrap, m_wrap, h_wrap;

   // bits of the packed load word with no storage behind them
   logic        unused_load;
   assign unused_load = ^{load_time[31:29], load_time[26]};

   // Carry only on the exact terminal value; out-of-range values wrap at the
   // field width without rippling into the next field.
   always_comb begin
      s_wrap   = (sec == 6'd59);
      m_wrap   = s_wrap && (min == 6'd59);
      h_wrap   = m_wrap && (hour == 5'd23);
      inc_sec  = s_wrap ? 6'd0 : sec + 6'd1;
      inc_min  = min;
      if (s_wrap)
         inc_min = (min == 6'd59) ? 6'd0 : min + 6'd1;
      inc_hour = hour;
      if (m_wrap)
         inc_hour = (hour == 5'd23) ? 5'd0 : hour + 5'd1;
      inc_day  = h_wrap ? day + 9'd1 : day;
      inc_ovf  = ovf | (h_wrap && (day == 9'd511));
   end

   always_comb begin
      n_sec         = sec;
      n_min         = min;
      n_hour        = hour;
      n_day         = day;
      n_halt        = halt;
      n_ovf         = ovf;
      nl_sec        = l_sec;
      nl_min        = l_min;
      nl_hour       = l_hour;
      nl_day        = l_day;
      nl_halt       = l_halt;
      nl_ovf        = l_ovf;
      n_cu_state    = cu_state;
      n_latch_state = latch_state;
      n_cnt         = cnt;
      do_step       = 1'b0;
      do_copy       = 1'b0;

      if (load_valid) begin
         n_sec      = load_time[5:0];
         n_min      = load_time[11:6];
         n_hour     = load_time[16:12];
         n_day      = load_time[25:17];
         n_ovf      = load_time[27];
         n_halt     = load_time[28];
         n_cnt      = load_diff;
         n_cu_state = ((load_diff != 32'd0) && !load_time[28]) ? CU_CATCHUP : CU_IDLE;
      end else begin
         // a halt raised while catching up abandons the remaining seconds
         if ((cu_state == CU_CATCHUP) && halt) begin
            n_cu_state = CU_IDLE;
            n_cnt      = 32'd0;
         end

         if (reg_wr) begin
            case (reg_idx)
               3'd0: begin
                  n_sec  = wr_data[5:0];
                  nl_sec = wr_data[5:0];
               end
               3'd1: begin
                  n_min  = wr_data[5:0];
                  nl_min = wr_data[5:0];
               end
               3'd2: begin
                  n_hour  = wr_data[4:0];
                  nl_hour = wr_data[4:0];
               end
               3'd3: begin
                  n_day[7:0]  = wr_data;
                  nl_day[7:0] = wr_data;
               end
               3'd4: begin
                  n_day[8]  = wr_data[0];
                  nl_day[8] = wr_data[0];
                  n_halt    = wr_data[6];
                  nl_halt   = wr_data[6];
                  n_ovf     = wr_data[7];
                  nl_ovf    = wr_data[7];
               end
               default: begin
               end
            endcase
         end else if (latch_wr) begin
            if (wr_data == 8'h00) begin
               n_latch_state = LT_ARMED;
            end else if ((wr_data == 8'h01) && (latch_state == LT_ARMED)) begin
               do_copy       = 1'b1;
               n_latch_state = LT_ARMED_N;
            end else begin
               n_latch_state = LT_ARMED_N;
            end
         end else if (sec_tick) begin
            // a real tick takes the cycle; any catch-up step waits
            do_step = !halt;
         end else if ((cu_state == CU_CATCHUP) && !halt) begin
            do_step = 1'b1;
            n_cnt   = cnt - 32'd1;
            if (cnt <= 32'd1)
               n_cu_state = CU_IDLE;
         end
      end

      if (do_step) begin
         n_sec  = inc_sec;
         n_min  = inc_min;
         n_hour = inc_hour;
         n_day  = inc_day;
         n_ovf  = inc_ovf;
      end

      if (do_copy) begin
         nl_sec  = sec;
         nl_min  = min;
         nl_hour = hour;
         nl_day  = day;
         nl_halt = halt;
         nl_ovf  = ovf;
      end

      live_change = ({n_sec, n_min, n_hour, n_day, n_halt, n_ovf} !=
                     {sec, min, hour, day, halt, ovf});
   end

   always_ff @(posedge clk_sys) begin
      if (reset || !enable) begin
         sec         <= 6'd0;
         min         <= 6'd0;
         hour        <= 5'd0;
         day         <= 9'd0;
         halt        <= 1'b0;
         ovf         <= 1'b0;
         l_sec       <= 6'd0;
         l_min       <= 6'd0;
         l_hour      <= 5'd0;
         l_day       <= 9'd0;
         l_halt      <= 1'b0;
         l_ovf       <= 1'b0;
         cu_state    <= CU_IDLE;
         latch_state <= LT_ARMED_N;
         cnt         <= 32'd0;
         saved_time  <= 32'd0;
      end else begin
         sec         <= n_sec;
         min         <= n_min;
         hour        <= n_hour;
         day         <= n_day;
         halt        <= n_halt;
         ovf         <= n_ovf;
         l_sec       <= nl_sec;
         l_min       <= nl_min;
         l_hour      <= nl_hour;
         l_day       <= nl_day;
         l_halt      <= nl_halt;
         l_ovf       <= nl_ovf;
         cu_state    <= n_cu_state;
         latch_state <= n_latch_state;
         cnt         <= n_cnt;
         // only publish a snapshot of a settled clock
         if ((cu_state == CU_IDLE) && !live_change)
            saved_time <= {3'b000, halt, ovf, 1'b0, day, hour, min, sec};
      end
   end

   assign busy = (cu_state == CU_CATCHUP);

   always_comb begin
      case (reg_idx)
         3'd0:    rd_data = {2'b00, l_sec};
         3'd1:    rd_data = {2'b00, l_min};
         3'd2:    rd_data = {3'b000, l_hour};
         3'd3:    rd_data = l_day[7:0];
         3'd4:    rd_data = {l_ovf, l_halt, 5'b00000, l_day[8]};
         default: rd_data = 8'hFF;
      endcase
   end

endmodule
